// File: rtl/modbus_rtu_frame_rx_pkg.sv
// ============================================================================
// Module : modbus_rtu_frame_rx_pkg
// Brief  : Shared types and constants for the Modbus RTU receive/transmit path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package modbus_rtu_frame_rx_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_RECV = 3'd2,
        S_GAP  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLY  = 16'hA001;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam int          MIN_FRAME = 4;
    localparam int          MAX_ADU   = 256;

    // Above 19200 baud the inter-character timeouts are fixed at 750 us / 1750 us.
    function automatic logic [23:0] tmr_thresh(input int clk_freq, input int baud,
                                               input logic long_gap);
        if (baud <= 19200) begin
            return long_gap ? 24'((clk_freq / baud) * 77 / 2)
                            : 24'((clk_freq / baud) * 33 / 2);
        end
        return long_gap ? 24'((clk_freq / 1000000) * 1750)
                        : 24'((clk_freq / 1000000) * 750);
    endfunction

endpackage

`default_nettype wire

// File: rtl/modbus_crc16.sv
// ============================================================================
// Module : modbus_crc16
// Brief  : Combinational CRC-16/MODBUS byte update, 8 bit steps unrolled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module modbus_crc16
    import modbus_rtu_frame_rx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] w_crc;

    always_comb begin
        w_crc = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC_POLY) : (w_crc >> 1);
        end
        crc_out = w_crc;
    end

endmodule

`default_nettype wire

// File: rtl/modbus_rtu_frame_rx.sv
// ============================================================================
// Module : modbus_rtu_frame_rx
// Brief  : Modbus RTU frame assembler with t1.5/t3.5 delimiting and CRC check.
//          Optional MODBUS_ADDR_FILTER_EN discards frames not for slave_addr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module modbus_rtu_frame_rx
    import modbus_rtu_frame_rx_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int MAX_FRAME = MAX_ADU
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic [7:0] slave_addr,
    output logic       frame_valid,
    input  logic       frame_ack,
    output logic [8:0] frame_len,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_drop,
    output logic       ovr_err
);

    localparam logic [23:0] C_T15     = tmr_thresh(CLK_FREQ, BAUD_RATE, 1'b0);
    localparam logic [23:0] C_T35     = tmr_thresh(CLK_FREQ, BAUD_RATE, 1'b1);
    localparam logic [8:0]  C_MAX_LEN = 9'(MAX_FRAME);
    localparam logic [8:0]  C_MIN_LEN = 9'(MIN_FRAME);
    localparam int          C_AW      = $clog2(MAX_FRAME);

    state_t      r_state, w_state_nxt;
    logic [23:0] r_timer;
    logic [8:0]  r_len;
    logic [15:0] r_crc, w_crc_nxt;
    logic        r_bad, r_ovf, r_valid, r_drop, r_ovr;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_buf [MAX_FRAME];

    logic w_store, w_crc_upd, w_clear, w_set_bad, w_set_ovf, w_drop, w_ovr;
    logic w_frame_ok, w_addr_ok;

`ifdef MODBUS_ADDR_FILTER_EN
    logic [7:0] r_addr0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                           r_addr0 <= 8'h00;
        else if (w_store && r_state == S_IDLE)   r_addr0 <= rx_data;
    end

    assign w_addr_ok = (r_addr0 == slave_addr) || (r_addr0 == 8'h00);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^slave_addr;
    assign w_addr_ok     = 1'b1;
`endif

    modbus_crc16 u_crc (
        .crc_in  (r_crc),
        .data_in (rx_data),
        .crc_out (w_crc_nxt)
    );

    // Residual CRC over data plus transmitted CRC is zero for an intact frame.
    assign w_frame_ok = !r_bad && !r_ovf && (r_len >= C_MIN_LEN) && (r_crc == 16'h0000);

    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_crc_upd   = 1'b0;
        w_clear     = 1'b0;
        w_set_bad   = 1'b0;
        w_set_ovf   = 1'b0;
        w_drop      = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            S_INIT: begin
                if (!rx_done && r_timer >= C_T35) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (rx_done) begin
                    w_store     = 1'b1;
                    w_crc_upd   = 1'b1;
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_done) begin
                    if (r_len < C_MAX_LEN) begin
                        w_store   = 1'b1;
                        w_crc_upd = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end else if (r_timer >= C_T15) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (rx_done) begin
                    w_set_bad = 1'b1;
                end else if (r_timer >= C_T35) begin
                    if (!w_addr_ok) begin
                        w_clear     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_frame_ok) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_drop      = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                w_ovr = rx_done;
                if (frame_ack) begin
                    w_clear     = 1'b1;
                    // A byte arriving with the ack means the line is not silent.
                    w_state_nxt = (r_timer >= C_T35 && !rx_done) ? S_IDLE : S_INIT;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_INIT;
            r_timer <= 24'd0;
            r_len   <= 9'd0;
            r_crc   <= CRC_INIT;
            r_bad   <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == S_HOLD);
            r_drop  <= w_drop;
            r_ovr   <= w_ovr;
            if (rx_done)              r_timer <= 24'd0;
            else if (r_timer < C_T35) r_timer <= r_timer + 24'd1;
            if (w_clear) begin
                r_len <= 9'd0;
                r_crc <= CRC_INIT;
                r_bad <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                if (w_store)   r_len <= r_len + 9'd1;
                if (w_crc_upd) r_crc <= w_crc_nxt;
                if (w_set_bad) r_bad <= 1'b1;
                if (w_set_ovf) r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_store) r_buf[r_len[C_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_rd_data <= 8'h00;
        else           r_rd_data <= r_buf[rd_addr[C_AW-1:0]];
    end

    assign frame_valid = r_valid;
    assign frame_len   = r_len;
    assign rd_data     = r_rd_data;
    assign frame_drop  = r_drop;
    assign ovr_err     = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_modbus_rtu_frame_rx.sv
// ============================================================================
// Module : tb_modbus_rtu_frame_rx
// Brief  : Directed self-checking bench; scaled clock gives 10-cycle bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_modbus_rtu_frame_rx;

    localparam int CLK_FREQ = 96000;
    localparam int BAUD     = 9600;
    localparam int CHAR     = 110;   // 11 bit times per character
    localparam int T35      = 385;   // 10 * 77 / 2

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] slave_addr = 8'h05;
    logic       frame_valid;
    logic       frame_ack = 1'b0;
    logic [8:0] frame_len;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       frame_drop;
    logic       ovr_err;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int ovr_cnt = 0;

    logic [7:0] f_good [8];
    logic [7:0] f_bad  [8];
    logic [7:0] f_two  [8];
    logic [7:0] f_bc   [8];
    logic [7:0] f_min  [8];

    modbus_rtu_frame_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .MAX_FRAME (256)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .slave_addr  (slave_addr),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_len   (frame_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_drop  (frame_drop),
        .ovr_err     (ovr_err)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_drop) drop_cnt++;
        if (ovr_err)    ovr_cnt++;
    end

    function automatic logic [15:0] model_crc(input logic [7:0] d [8], input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, d[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk_in);
        rx_done = 1'b0;
        repeat (CHAR - 2) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] f [8], input int n, input int gap_at, input int gap);
        for (int i = 0; i < n; i++) begin
            send_byte(f[i]);
            if (i == gap_at) repeat (gap) @(negedge clk_in);
        end
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!frame_valid && n < bound) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic read_buf(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk_in);
        rd_addr = a;
        @(negedge clk_in);
        d = rd_data;
    endtask

    task automatic do_ack();
        @(negedge clk_in);
        frame_ack = 1'b1;
        @(negedge clk_in);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({frame_valid, frame_drop, ovr_err, frame_len, rd_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_hold outputs=%h required 0", {frame_valid, frame_drop, ovr_err, frame_len, rd_data});
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if ({frame_valid, frame_drop, ovr_err, frame_len} !== 12'h0) begin
            errors++;
            $display("FAIL reset_release outputs=%h required 0", {frame_valid, frame_drop, ovr_err, frame_len});
        end
    endtask

    task automatic test_good_frame();
        int n, d0;
        logic [7:0] b;
        repeat (T35 + 20) @(negedge clk_in);
        d0 = drop_cnt;
        send_frame(f_good, 8, -1, 0);
        wait_valid(600, n);
        checks++;
        if (!frame_valid || (n + CHAR - 1) < 380 || (n + CHAR - 1) > 395) begin
            errors++;
            $display("FAIL good_valid_timing valid=%0b cycles=%0d required 1 within 380..395", frame_valid, n + CHAR - 1);
        end
        checks++;
        if (frame_len !== 9'd8) begin
            errors++;
            $display("FAIL good_len got=%0d required 8", frame_len);
        end
        read_buf(8'd0, b);
        checks++;
        if (b !== 8'h01) begin errors++; $display("FAIL good_buf0 got=%h required 01", b); end
        read_buf(8'd6, b);
        checks++;
        if (b !== 8'h84) begin errors++; $display("FAIL good_buf6 got=%h required 84", b); end
        read_buf(8'd7, b);
        checks++;
        if (b !== 8'h0A) begin errors++; $display("FAIL good_buf7 got=%h required 0A", b); end
        do_ack();
        checks++;
        if (frame_valid !== 1'b0 || frame_len !== 9'd0 || drop_cnt != d0) begin
            errors++;
            $display("FAIL good_ack valid=%0b len=%0d drops=%0d required 0 0 %0d", frame_valid, frame_len, drop_cnt, d0);
        end
    endtask

    task automatic test_bad_crc();
        int d0;
        d0 = drop_cnt;
        send_frame(f_bad, 8, -1, 0);
        repeat (500) @(negedge clk_in);
        checks++;
        if (drop_cnt != d0 + 1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_crc drops=%0d valid=%0b required %0d 0", drop_cnt - d0, frame_valid, 1);
        end
    endtask

    task automatic test_gap();
        int d0;
        d0 = drop_cnt;
        send_frame(f_good, 8, 3, 66);
        repeat (500) @(negedge clk_in);
        checks++;
        if (drop_cnt != d0 + 1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_gap drops=%0d valid=%0b required 1 0", drop_cnt - d0, frame_valid);
        end
    endtask

    task automatic test_min_len();
        int d0, n;
        d0 = drop_cnt;
        send_frame(f_good, 3, -1, 0);
        repeat (500) @(negedge clk_in);
        checks++;
        if (drop_cnt != d0 + 1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_frame drops=%0d valid=%0b required 1 0", drop_cnt - d0, frame_valid);
        end
        send_frame(f_min, 4, -1, 0);
        wait_valid(600, n);
        checks++;
        if (frame_valid !== 1'b1 || frame_len !== 9'd4) begin
            errors++;
            $display("FAIL min_frame valid=%0b len=%0d required 1 4", frame_valid, frame_len);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int n, o0, d0;
        logic [7:0] b;
        send_frame(f_good, 8, -1, 0);
        wait_valid(600, n);
        o0 = ovr_cnt;
        send_frame(f_two, 7, -1, 0);
        read_buf(8'd1, b);
        checks++;
        if (frame_valid !== 1'b1 || frame_len !== 9'd8 || b !== 8'h03) begin
            errors++;
            $display("FAIL hold_intact valid=%0b len=%0d buf1=%h required 1 8 03", frame_valid, frame_len, b);
        end
        @(negedge clk_in);
        rx_data   = f_two[7];
        rx_done   = 1'b1;
        frame_ack = 1'b1;
        @(negedge clk_in);
        rx_done   = 1'b0;
        frame_ack = 1'b0;
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_with_byte valid=%0b required 0", frame_valid);
        end
        @(negedge clk_in);
        checks++;
        if (ovr_cnt != o0 + 8) begin
            errors++;
            $display("FAIL ovr_pulses got=%0d required 8", ovr_cnt - o0);
        end
        d0 = drop_cnt;
        send_frame(f_good, 8, -1, 0);
        wait_valid(600, n);
        checks++;
        if (frame_valid !== 1'b0 || drop_cnt != d0) begin
            errors++;
            $display("FAIL post_ack_init valid=%0b drops=%0d required 0 0", frame_valid, drop_cnt - d0);
        end
        send_frame(f_two, 8, -1, 0);
        wait_valid(600, n);
        read_buf(8'd1, b);
        checks++;
        if (frame_valid !== 1'b1 || frame_len !== 9'd8 || b !== 8'h06) begin
            errors++;
            $display("FAIL after_silence valid=%0b len=%0d buf1=%h required 1 8 06", frame_valid, frame_len, b);
        end
        do_ack();
    endtask

    task automatic test_filter();
        int n, d0;
        logic exp_v;
        slave_addr = 8'h05;
`ifdef MODBUS_ADDR_FILTER_EN
        exp_v = 1'b0;
`else
        exp_v = 1'b1;
`endif
        d0 = drop_cnt;
        send_frame(f_good, 8, -1, 0);
        wait_valid(600, n);
        checks++;
        if (frame_valid !== exp_v || drop_cnt != d0) begin
            errors++;
            $display("FAIL filter_other valid=%0b drops=%0d required %0b 0", frame_valid, drop_cnt - d0, exp_v);
        end
        if (frame_valid) do_ack();
        send_frame(f_bc, 8, -1, 0);
        wait_valid(600, n);
        checks++;
        if (frame_valid !== 1'b1 || frame_len !== 9'd8) begin
            errors++;
            $display("FAIL filter_broadcast valid=%0b len=%0d required 1 8", frame_valid, frame_len);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int n, d0;
        send_frame(f_good, 4, -1, 0);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({frame_valid, frame_drop, ovr_err, frame_len} !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid outputs=%h required 0", {frame_valid, frame_drop, ovr_err, frame_len});
        end
        rst_n_in = 1'b1;
        d0 = drop_cnt;
        send_frame(f_good, 8, -1, 0);
        wait_valid(600, n);
        checks++;
        if (frame_valid !== 1'b0 || drop_cnt != d0) begin
            errors++;
            $display("FAIL early_bytes valid=%0b drops=%0d required 0 0", frame_valid, drop_cnt - d0);
        end
        send_frame(f_good, 8, -1, 0);
        wait_valid(600, n);
        checks++;
        if (frame_valid !== 1'b1 || frame_len !== 9'd8) begin
            errors++;
            $display("FAIL after_init valid=%0b len=%0d required 1 8", frame_valid, frame_len);
        end
        do_ack();
    endtask

    initial begin
        logic [15:0] c;
        f_good = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        f_bad  = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B};
        f_two  = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        f_bc   = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        c = model_crc(f_bc, 6);
        f_bc[6] = c[7:0];
        f_bc[7] = c[15:8];
        f_min  = '{8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        c = model_crc(f_min, 2);
        f_min[2] = c[7:0];
        f_min[3] = c[15:8];

        test_reset();
        test_good_frame();
        test_bad_crc();
        test_gap();
        test_min_len();
        test_back_to_back();
        test_filter();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
